// File: rtl/otp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otp_pkg
// Description : Shared encodings for the OTP host sequencer: controller mode
//               codes, command opcodes, sequencer state enum and the nominal
//               read-strobe latency.
//               Optional feature macro: OTP_VERIFY_EN (adds verify states).
// Revision    : 1.0 - initial release
// ============================================================================
package otp_pkg;

  // Mode codes driven to the OTP array controller
  localparam logic [1:0] MODE_WRITING = 2'b00;
  localparam logic [1:0] MODE_READING = 2'b01;
  localparam logic [1:0] MODE_IDLE    = 2'b10;

  // Cycles from the issue edge to the controller's nominal reading strobe
  localparam int NOMINAL_RD_LATENCY = 4;

  // Command opcode carried on req_op
  typedef enum logic {
    OP_PROG = 1'b0,
    OP_READ = 1'b1
  } op_e;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_RD   = 3'd2,
    S_WAIT_WR   = 3'd3,
    S_RESP      = 3'd4
`ifdef OTP_VERIFY_EN
    ,
    S_VFY_ISSUE = 3'd5,
    S_VFY_WAIT  = 3'd6
`endif
  } state_e;

endpackage : otp_pkg
`default_nettype wire

// File: rtl/otp_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : otp_cycle_timer
// Description : Loadable saturating up-counter with synchronous clear, count
//               enable and a terminal-count compare against a run-time value.
//               Shared by the write wait and the read timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module otp_cycle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear beats load beats increment; stick at all-ones
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == tc_val_i);

endmodule : otp_cycle_timer
`default_nettype wire

// File: rtl/otp_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : otp_host_sequencer
// Description : Initiator for the OTP array controller mode/addr interface.
//               Accepts one read/program command at a time, emits a single
//               cycle mode pulse, holds addr for the whole operation, waits
//               for the read strobe or the program sequence, and returns a
//               response on a valid/ready channel.
//               Optional feature macro: OTP_VERIFY_EN (read-back verify after
//               every program).
// Revision    : 1.0 - initial release
// ============================================================================
module otp_host_sequencer
  import otp_pkg::*;
#(
  parameter int WRITE_CYCLES = 12,
  parameter int READ_TIMEOUT = 8,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [1:0] req_addr,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_data,
  output logic       rsp_err,
  output logic [1:0] mode,
  output logic [1:0] addr,
  input  logic       reading,
  input  logic       sense_in
);

  // Terminal counts: the timer starts at 0 on the first wait cycle
  localparam logic [CNT_W-1:0] WR_TC = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_TC = CNT_W'(READ_TIMEOUT - 1);

  state_e     state_q;
  op_e        op_q;
  logic [1:0] addr_q;
  logic [1:0] mode_q;
  logic       req_ready_q;
  logic       rsp_valid_q;
  logic       rsp_data_q;
  logic       rsp_err_q;

  logic             tmr_clear;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_tc_val;
  logic             tmr_tc;

  // Timer control: cleared in issue cycles, counting in wait states
  always_comb begin
    tmr_clear  = (state_q == S_ISSUE);
    tmr_en     = (state_q == S_WAIT_RD) || (state_q == S_WAIT_WR);
    tmr_tc_val = (state_q == S_WAIT_WR) ? WR_TC : RD_TC;
`ifdef OTP_VERIFY_EN
    tmr_clear  = tmr_clear || (state_q == S_VFY_ISSUE);
    tmr_en     = tmr_en || (state_q == S_VFY_WAIT);
`endif
  end

  otp_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (tmr_clear),
    .load_i     (1'b0),
    .load_val_i ({CNT_W{1'b0}}),
    .en_i       (tmr_en),
    .tc_val_i   (tmr_tc_val),
    .tc_o       (tmr_tc)
  );

  // Sequencer FSM with all interface outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_PROG;
      addr_q      <= 2'b00;
      mode_q      <= MODE_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= op_e'(req_op);
            addr_q      <= req_addr;
            mode_q      <= (op_e'(req_op) == OP_READ) ? MODE_READING : MODE_WRITING;
            req_ready_q <= 1'b0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mode_q  <= MODE_IDLE;
          state_q <= (op_q == OP_READ) ? S_WAIT_RD : S_WAIT_WR;
        end
        S_WAIT_RD: begin
          // A strobe on the timeout cycle still counts as a good read
          if (reading) begin
            rsp_data_q  <= sense_in;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (tmr_tc) begin
            rsp_data_q  <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_WAIT_WR: begin
          if (tmr_tc) begin
`ifdef OTP_VERIFY_EN
            mode_q      <= MODE_READING;
            state_q     <= S_VFY_ISSUE;
`else
            rsp_data_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
`endif
          end
        end
`ifdef OTP_VERIFY_EN
        S_VFY_ISSUE: begin
          mode_q  <= MODE_IDLE;
          state_q <= S_VFY_WAIT;
        end
        S_VFY_WAIT: begin
          // A programmed cell must read back as 1
          if (reading) begin
            rsp_data_q  <= sense_in;
            rsp_err_q   <= ~sense_in;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (tmr_tc) begin
            rsp_data_q  <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
`endif
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          mode_q      <= MODE_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mode      = mode_q;
  assign addr      = addr_q;

endmodule : otp_host_sequencer
`default_nettype wire

// File: tb/tb_otp_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_otp_host_sequencer
// Description : Self-checking bench for otp_host_sequencer. A transaction
//               model derives the response cycle, data/error and the mode
//               pulse schedule from the strobe delay chosen for each command.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otp_host_sequencer;
  import otp_pkg::*;

  localparam int WRITE_CYCLES = 12;
  localparam int READ_TIMEOUT = 8;
  localparam int CNT_W        = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [1:0] req_addr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_data;
  logic       rsp_err;
  logic [1:0] mode;
  logic [1:0] addr;
  logic       reading;
  logic       sense_in;

  int checks = 0;
  int errors = 0;

  otp_host_sequencer #(
    .WRITE_CYCLES (WRITE_CYCLES),
    .READ_TIMEOUT (READ_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mode      (mode),
    .addr      (addr),
    .reading   (reading),
    .sense_in  (sense_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One command end to end. Cycle k=0 is the issue cycle (first cycle after
  // acceptance). d is the strobe delay in cycles after the relevant issue
  // cycle (the read issue, or the verify issue for programs with verify).
  task automatic run_txn(input logic op, input logic [1:0] a, input int d,
                         input logic s, input int stall);
    int   rc;        // cycle index at which rsp_valid must first be seen
    int   strobe_k;  // cycle index at which the controller raises reading
    int   win_lo;    // cycles where a strobe would be sampled
    int   win_hi;
    int   vfy_k;     // cycle index of the verify read pulse (-1: none)
    logic ed;
    logic ee;
    logic [1:0] em;
    logic rd_ok;

    rd_ok = (d >= 1) && (d <= READ_TIMEOUT);
    vfy_k = -1;
    if (op) begin
      win_lo   = 1;
      win_hi   = READ_TIMEOUT;
      strobe_k = d;
      rc       = rd_ok ? d + 1 : READ_TIMEOUT + 1;
      ed       = rd_ok ? s : 1'b0;
      ee       = rd_ok ? 1'b0 : 1'b1;
    end else begin
`ifdef OTP_VERIFY_EN
      vfy_k    = WRITE_CYCLES + 1;
      win_lo   = vfy_k + 1;
      win_hi   = vfy_k + READ_TIMEOUT;
      strobe_k = vfy_k + d;
      rc       = rd_ok ? strobe_k + 1 : vfy_k + READ_TIMEOUT + 1;
      ed       = rd_ok ? s : 1'b0;
      ee       = rd_ok ? ~s : 1'b1;
`else
      win_lo   = -10;
      win_hi   = -10;
      strobe_k = -10;
      rc       = WRITE_CYCLES + 1;
      ed       = 1'b0;
      ee       = 1'b0;
`endif
    end

    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    reading   = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 1'($urandom);
    req_addr  = 2'($urandom);

    for (int k = 0; k <= rc; k++) begin
      @(negedge clk);
      // Controller strobe model; outside the sampling window it may toggle freely
      if (k == strobe_k) begin
        reading  = 1'b1;
        sense_in = s;
      end else if (k >= win_lo && k <= win_hi) begin
        reading  = 1'b0;
        sense_in = 1'($urandom);
      end else begin
        reading  = 1'($urandom);
        sense_in = 1'($urandom);
      end
      if (k == 0)          em = op ? 2'b01 : 2'b00;
      else if (k == vfy_k) em = 2'b01;
      else                 em = 2'b10;
      chk("mode", 8'(mode), 8'(em));
      chk("addr_hold", 8'(addr), 8'(a));
      chk("req_ready_busy", 8'(req_ready), 8'd0);
      if (k < rc) begin
        chk("rsp_valid_early", 8'(rsp_valid), 8'd0);
      end else begin
        chk("rsp_valid", 8'(rsp_valid), 8'd1);
        chk("rsp_data", 8'(rsp_data), 8'(ed));
        chk("rsp_err", 8'(rsp_err), 8'(ee));
      end
    end

    // Back-pressure: a pending request must not start anything
    for (int i = 0; i < stall; i++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_op    = 1'($urandom);
      req_addr  = 2'($urandom);
      reading   = 1'($urandom);
      sense_in  = 1'($urandom);
      @(negedge clk);
      chk("stall_valid", 8'(rsp_valid), 8'd1);
      chk("stall_data", 8'(rsp_data), 8'(ed));
      chk("stall_err", 8'(rsp_err), 8'(ee));
      chk("stall_mode", 8'(mode), 8'(2'b10));
      chk("stall_ready", 8'(req_ready), 8'd0);
      chk("stall_addr", 8'(addr), 8'(a));
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    reading   = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", 8'(rsp_valid), 8'd0);
    chk("post_ready", 8'(req_ready), 8'd1);
    chk("post_mode", 8'(mode), 8'(2'b10));
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_addr  = 2'b00;
    rsp_ready = 1'b0;
    reading   = 1'b0;
    sense_in  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 8'(req_ready), 8'd1);
    chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("rst_rsp_data", 8'(rsp_data), 8'd0);
    chk("rst_rsp_err", 8'(rsp_err), 8'd0);
    chk("rst_mode", 8'(mode), 8'(2'b10));
    chk("rst_addr", 8'(addr), 8'd0);
    reset = 1'b0;

    // Directed cases
    run_txn(1'b1, 2'b01, NOMINAL_RD_LATENCY, 1'b1, 0);
    run_txn(1'b0, 2'b10, NOMINAL_RD_LATENCY, 1'b1, 0);
    run_txn(1'b1, 2'b00, 100, 1'b1, 0);
    run_txn(1'b1, 2'b11, NOMINAL_RD_LATENCY, 1'b1, 5);
    run_txn(1'b1, 2'b10, READ_TIMEOUT, 1'b1, 0);
    run_txn(1'b1, 2'b01, 1, 1'b0, 1);
    run_txn(1'b0, 2'b11, NOMINAL_RD_LATENCY, 1'b0, 0);
    run_txn(1'b0, 2'b01, READ_TIMEOUT + 1, 1'b1, 2);

    // Reset in the middle of a program wait
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_addr  = 2'b11;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_mode", 8'(mode), 8'(2'b10));
    chk("midrst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("midrst_req_ready", 8'(req_ready), 8'd1);
    chk("midrst_addr", 8'(addr), 8'd0);
    reset = 1'b0;
    run_txn(1'b1, 2'b10, NOMINAL_RD_LATENCY, 1'b1, 0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      run_txn(1'($urandom), 2'($urandom), int'($urandom_range(1, READ_TIMEOUT + 2)),
              1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_otp_host_sequencer
`default_nettype wire
